// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit
//  Description : Instruction-fetch stage. Owns the PC, issues in-order imem
//                requests, buffers returned words with their PCs and presents
//                them to IF/ID. Handles stall and branch/jump redirect with flush.
//                Optional perf counters enabled by FETCH_PERF_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] IR_out,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubble,
`endif
    output logic [31:0] PC_out
);

    localparam int                 c_PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int                 c_DROP_W = 16;
    localparam logic [c_PTR_W:0]   c_DEPTH  = (c_PTR_W+1)'(BUF_DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [c_PTR_W:0]    r_head;
    logic [c_PTR_W:0]    r_fill;
    logic [c_PTR_W:0]    r_tail;
    logic [31:0]         r_fetch_pc;
    logic [c_DROP_W-1:0] r_drop_cnt;
    logic [31:0]         r_slot_pc [BUF_DEPTH];
    logic [31:0]         r_slot_ir [BUF_DEPTH];

    logic [c_PTR_W:0]    w_used;
    logic [c_PTR_W:0]    w_unfilled;
    logic [c_PTR_W-1:0]  w_head_idx;
    logic [c_PTR_W-1:0]  w_fill_idx;
    logic [c_PTR_W-1:0]  w_tail_idx;
    logic                w_head_ready;
    logic                w_alloc;
    logic                w_fill;
    logic                w_drop;
    logic                w_pop;
    logic [c_DROP_W-1:0] w_drop_sum;
    logic [c_DROP_W-1:0] w_drop_redirect;

    assign w_used       = r_tail - r_head;
    assign w_unfilled   = r_tail - r_fill;
    assign w_head_idx   = r_head[c_PTR_W-1:0];
    assign w_fill_idx   = r_fill[c_PTR_W-1:0];
    assign w_tail_idx   = r_tail[c_PTR_W-1:0];
    assign w_head_ready = (r_fill != r_head);

    // Request is a function of registered occupancy only: no gnt->req path.
    assign imem_req  = rst_n & ~redirect & (w_used < c_DEPTH);
    assign imem_addr = r_fetch_pc;

    assign out_valid = w_head_ready & ~redirect;
    assign IR_out    = r_slot_ir[w_head_idx];
    assign PC_out    = r_slot_pc[w_head_idx];

    assign w_alloc = imem_req & imem_gnt;
    assign w_drop  = imem_rvalid & (r_drop_cnt != '0);
    assign w_fill  = imem_rvalid & (r_drop_cnt == '0) & (w_unfilled != '0);
    assign w_pop   = out_valid & ~stall;

    // Every in-flight response of the abandoned stream must be swallowed,
    // including one that happens to return during the redirect cycle itself.
    assign w_drop_sum      = r_drop_cnt + {{(c_DROP_W-c_PTR_W-1){1'b0}}, w_unfilled};
    assign w_drop_redirect = (imem_rvalid && (w_drop_sum != '0)) ? (w_drop_sum - 1'b1) : w_drop_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_fill     <= '0;
            r_tail     <= '0;
            r_fetch_pc <= RESET_PC;
            r_drop_cnt <= '0;
        end else if (redirect) begin
            r_head     <= '0;
            r_fill     <= '0;
            r_tail     <= '0;
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            r_drop_cnt <= w_drop_redirect;
        end else begin
            if (w_alloc) begin
                r_tail     <= r_tail + 1'b1;
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_fill) begin
                r_fill <= r_fill + 1'b1;
            end
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
        end
    end

    // Allocation and fill never target the same slot in one cycle: a fill
    // needs an unfilled slot, an allocation needs a free one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_slot_pc[i] <= '0;
                r_slot_ir[i] <= '0;
            end
        end else begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if (w_alloc && (w_tail_idx == c_PTR_W'(i))) begin
                    r_slot_pc[i] <= r_fetch_pc;
                end
                if (w_fill && (w_fill_idx == c_PTR_W'(i))) begin
                    r_slot_ir[i] <= imem_rdata;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubble;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_bubble  <= '0;
        end else begin
            if (out_valid && !stall) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (!out_valid && !stall && !redirect) begin
                r_perf_bubble <= r_perf_bubble + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_bubble  = r_perf_bubble;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// Testbench for if_fetch_unit: in-order memory responder, stream-level
// reference model checked every cycle, plus directed scenario checks.
module tb_if_fetch_unit;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] KEY    = 32'hA5A5_A5A5;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] IR_out;
    logic [31:0] PC_out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubble;
    logic [31:0] m_fetched;
    logic [31:0] m_bubble;
`endif

    if_fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .IR_out      (IR_out),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched(perf_fetched),
        .perf_bubble (perf_bubble),
`endif
        .PC_out      (PC_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_ent_t;

    mem_ent_t    mem_q[$];   // requests accepted by memory, oldest first
    logic [31:0] rdy_q[$];   // PCs of live words returned, awaiting delivery
    int          m_stale;    // oldest in-flight requests belonging to a dead stream
    logic [31:0] m_pc;
    int          cyc;
    int          lat;
    int          first_req_cyc;
    logic [31:0] dlv_pc[$];
    int          dlv_cyc[$];
    int          n_chk;
    int          n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare and model-advance process: all DUT outputs sampled mid-cycle.
    always @(negedge clk) begin : p_compare
        mem_ent_t ent;
        logic     exp_req;
        logic     exp_ov;
        int       used;
        if (!rst_n) begin
            chk("rst_imem_req", 32'(imem_req), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_IR_out", IR_out, 32'd0);
            chk("rst_PC_out", PC_out, 32'd0);
            chk("rst_imem_addr", imem_addr, RST_PC);
`ifdef FETCH_PERF_CNT_EN
            chk("rst_perf_fetched", perf_fetched, 32'd0);
            chk("rst_perf_bubble", perf_bubble, 32'd0);
            m_fetched = 0;
            m_bubble  = 0;
`endif
            mem_q.delete();
            rdy_q.delete();
            m_stale       = 0;
            m_pc          = RST_PC;
            first_req_cyc = -1;
        end else begin
            used    = mem_q.size() - m_stale + rdy_q.size();
            exp_req = !redirect && (used < DEPTH);
            exp_ov  = !redirect && (rdy_q.size() > 0);
            chk("imem_req", 32'(imem_req), 32'(exp_req));
            if (exp_req) chk("imem_addr", imem_addr, m_pc);
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            if (exp_ov) begin
                chk("PC_out", PC_out, rdy_q[0]);
                chk("IR_out", IR_out, rdy_q[0] ^ KEY);
            end
`ifdef FETCH_PERF_CNT_EN
            chk("perf_fetched", perf_fetched, m_fetched);
            chk("perf_bubble", perf_bubble, m_bubble);
            if (exp_ov && !stall) m_fetched = m_fetched + 1;
            if (!exp_ov && !stall && !redirect) m_bubble = m_bubble + 1;
`endif
            if (imem_req && first_req_cyc < 0) first_req_cyc = cyc;
            if (out_valid && !stall) begin
                dlv_pc.push_back(PC_out);
                dlv_cyc.push_back(cyc);
            end
            if (exp_ov && !stall) void'(rdy_q.pop_front());
            if (imem_rvalid && mem_q.size() > 0) begin
                ent = mem_q.pop_front();
                if (m_stale > 0) m_stale--;
                else rdy_q.push_back(ent.addr);
            end
            if (redirect) begin
                rdy_q.delete();
                m_stale = mem_q.size();
                m_pc    = redirect_pc & 32'hFFFF_FFFC;
            end else if (exp_req && imem_gnt) begin
                ent.addr = m_pc;
                ent.due  = cyc + lat;
                mem_q.push_back(ent);
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
    end

    // Advance to just after the next rising edge and drive the memory response.
    task automatic step();
        @(posedge clk);
        #1;
        if (rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0].addr ^ KEY;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic wait_dlv(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (dlv_pc.size() < n && k < budget) begin
            step();
            k++;
        end
        if (dlv_pc.size() < n) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: timeout, %0d deliveries seen, %0d required", name, dlv_pc.size(), n);
        end
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        step();
        redirect    = 1'b0;
    endtask

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin : p_main
        int   mark;
        logic found;
        logic [31:0] held_addr;
        n_chk = 0; n_fail = 0; cyc = 0; lat = 1;
        m_stale = 0; m_pc = RST_PC; first_req_cyc = -1;
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (3) step();
        rst_n = 1'b1;

        // Streaming: 0,4,8,... back to back, first word two cycles after first req
        mark = dlv_pc.size();
        wait_dlv(mark + 8, 40, "stream");
        if (dlv_pc.size() >= mark + 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("stream_pc", dlv_pc[mark+i], 32'(4*i));
                chk("stream_cyc", 32'(dlv_cyc[mark+i]), 32'(dlv_cyc[mark] + i));
            end
            chk("first_out_latency", 32'(dlv_cyc[mark] - first_req_cyc), 32'd2);
        end

        // Stall five cycles with head PC 0x10
        do_redirect(32'h10);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            #1;
            if (out_valid && PC_out == 32'h10) begin
                stall = 1'b1;
                found = 1'b1;
            end else begin
                step();
            end
        end
        chk("stall_head_found", 32'(found), 32'd1);
        mark = dlv_pc.size();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            #1;
            chk("stall_PC_hold", PC_out, 32'h10);
            chk("stall_IR_hold", IR_out, 32'h10 ^ KEY);
            chk("stall_valid_hold", 32'(out_valid), 32'd1);
        end
        chk("stall_req_full", 32'(imem_req), 32'd0);
        step();
        stall = 1'b0;
        wait_dlv(mark + 4, 30, "stall_release");
        if (dlv_pc.size() >= mark + 4) begin
            for (int i = 0; i < 4; i++) chk("stall_release_pc", dlv_pc[mark+i], 32'h10 + 32'(4*i));
        end

        // Two requests outstanding (0x20, 0x24) flushed by redirect to 0x103
        lat = 3;
        do_redirect(32'h20);
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        #1;
        chk("redir_req_low", 32'(imem_req), 32'd0);
        chk("redir_ov_low", 32'(out_valid), 32'd0);
        mark = dlv_pc.size();
        step();
        redirect = 1'b0;
        wait_dlv(mark + 2, 40, "redirect_flush");
        if (dlv_pc.size() >= mark + 2) begin
            chk("redir_first_pc", dlv_pc[mark], 32'h100);
            chk("redir_second_pc", dlv_pc[mark+1], 32'h104);
        end

        // Redirect coincident with stall and a returning response
        lat   = 2;
        stall = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (imem_rvalid && mem_q.size() >= 2) found = 1'b1;
        end
        chk("coincide_found", 32'(found), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        #1;
        chk("coincide_ov_low", 32'(out_valid), 32'd0);
        mark = dlv_pc.size();
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        wait_dlv(mark + 1, 40, "coincide");
        if (dlv_pc.size() >= mark + 1) chk("coincide_first_pc", dlv_pc[mark], 32'h200);

        // Grant withheld three cycles, then latency-4 in-order delivery
        lat = 4;
        do_redirect(32'h300);
        imem_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step();
            #1;
            if (k == 0) held_addr = imem_addr;
            chk("gnt_low_req", 32'(imem_req), 32'd1);
            chk("gnt_low_addr", imem_addr, 32'h300);
            chk("gnt_low_addr_stable", imem_addr, held_addr);
        end
        step();
        imem_gnt = 1'b1;
        mark = dlv_pc.size();
        wait_dlv(mark + 6, 60, "gnt_lat4");
        if (dlv_pc.size() >= mark + 6) begin
            for (int i = 0; i < 6; i++) chk("lat4_pc", dlv_pc[mark+i], 32'h300 + 32'(4*i));
        end

        // Asynchronous reset mid-stream, restart at RESET_PC
        lat = 1;
        repeat (3) step();
        #2;
        rst_n       = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        chk("async_rst_req", 32'(imem_req), 32'd0);
        chk("async_rst_ov", 32'(out_valid), 32'd0);
        chk("async_rst_IR", IR_out, 32'd0);
        chk("async_rst_PC", PC_out, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        mark = dlv_pc.size();
        wait_dlv(mark + 3, 30, "post_reset");
        if (dlv_pc.size() >= mark + 3) begin
            for (int i = 0; i < 3; i++) chk("post_reset_pc", dlv_pc[mark+i], RST_PC + 32'(4*i));
            chk("post_reset_latency", 32'(dlv_cyc[mark] - first_req_cyc), 32'd2);
        end

        repeat (4) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
